reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural register file for the single-cycle datapath.
- Sits directly upstream of the reduction/ALU stage and supplies its two 16-bit operands, A and B.
- Two asynchronous read ports and one synchronous write port, with internal write-before-read bypass.
- R0 is hardwired to zero.

Parameters:
- DATA_W, 16, width of each register and each data port.
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, 4, register-index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- src_reg1  input  ADDR_W  read index, port 1 (feeds operand A).
- src_reg2  input  ADDR_W  read index, port 2 (feeds operand B).
- dst_reg  input  ADDR_W  write index.
- write_reg  input  1  write enable.
- dst_data  input  DATA_W  write data.
- src_data1  output  DATA_W  read data, port 1.
- src_data2  output  DATA_W  read data, port 2.
- err  output  1  registered flag: a write targeting R0 was attempted.

Behaviour:
- Reset:
  - At a rising edge with rst=1, all NUM_REGS registers clear to 16'h0000 and err clears to 0.
  - While rst=1, src_data1 and src_data2 are forced to 0, bypass is disabled, and writes are ignored. Reset overrides a simultaneous write.
- Write:
  - At a rising edge with rst=0, write_reg=1 and dst_reg!=0, the register at dst_reg takes dst_data.
  - Otherwise all registers hold their value.
- R0:
  - Always reads 0.
  - A write to R0 is discarded. It sets err=1 on that edge, and err stays set until rst (sticky).
- Read:
  - Combinational, zero cycles latency.
  - src_dataN = mem[src_regN], except in the R0 and bypass cases.
- Bypass:
  - When write_reg=1, rst=0, dst_reg!=0 and dst_reg==src_regN, src_dataN = dst_data in the same cycle (write-before-read).
  - Both ports may bypass at the same time when src_reg1==src_reg2==dst_reg.
- Same index on both ports:
  - Both ports return identical data. No priority is involved.
- Back-to-back writes to the same register:
  - The last edge wins.
  - A read in the cycle after a write returns the newly stored value from storage, not from the bypass.
- Mid-operation reset:
  - A write presented in the same cycle as rst is lost.
  - The first cycle after rst deasserts reads 0 from every register.
- Width rules:
  - All data paths are exactly DATA_W wide, with no extension or truncation.
  - Indices at or above NUM_REGS cannot occur, because ADDR_W = log2(NUM_REGS).

Decomposition:
- Shared package rf_pkg:
  - DATA_W and ADDR_W constants.
  - ZERO_REG index (0).
  - Typedef reg_idx_t (ADDR_W bits) and word_t (DATA_W bits), reused by the decode and reduction stages.
- One natural sub-module, reg_cell:
  - A single DATA_W register with synchronous active-high reset and write enable.
  - reg_file instantiates NUM_REGS-1 of them (R1..R15). R0 is a constant 0, not a cell.
- Read muxes, bypass compare and err flag live in reg_file.

Test Plan:
1. Reset then read: assert rst for 2 edges, deassert, read R1 and R15 -> both ports 16'h0000, err=0.
2. Write then read: write R3=16'h1234 and R4=16'h5678 on consecutive edges, then src_reg1=3, src_reg2=4 -> src_data1=16'h1234, src_data2=16'h5678, matching the operands the downstream reduction stage consumes.
3. Bypass: write_reg=1, dst_reg=7, dst_data=16'hABCD, src_reg1=src_reg2=7 in the same cycle -> both outputs 16'hABCD before the edge. Next cycle with write_reg=0 -> still 16'hABCD, now from storage.
4. R0 protection: write R0=16'hFFFF -> src_data1(R0)=0 in the same cycle and after the edge, err=1 and stays 1 through 3 idle cycles, clears only on rst.
5. Reset priority: R5 holds 16'h00FF; assert rst together with a write of R5=16'h1111 -> after the edge R5 reads 0, and outputs are 0 while rst is high.
6. Sweep: write R1..R15 with 16'hFFFF minus the index, then read each pair (Rn, R16-n) -> exact values, with no aliasing between registers.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, index/word types and the hardwired-zero index.
package rf_pkg;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one architectural register with synchronous active-high reset and write enable.
module reg_cell
    import rf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  word_t d,
    output word_t q
);
    word_t data_d, data_q;

    always_comb data_d = we ? d : data_q;

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with write-before-read bypass, hardwired R0
// and a sticky flag for attempted R0 writes.
module reg_file
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t src_reg1,
    input  reg_idx_t src_reg2,
    input  reg_idx_t dst_reg,
    input  logic     write_reg,
    input  word_t    dst_data,
    output word_t    src_data1,
    output word_t    src_data2,
    output logic     err
);
    word_t regs [NUM_REGS];
    logic  wr_ok;
    logic  err_d, err_q;

    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
        reg_cell u_cell (
            .clk (clk),
            .rst (rst),
            .we  (wr_ok && dst_reg == reg_idx_t'(i)),
            .d   (dst_data),
            .q   (regs[i])
        );
    end

    // Bypass never matches R0 because wr_ok excludes it, so R0 reads stay zero.
    always_comb begin
        wr_ok     = write_reg && !rst && dst_reg != ZERO_REG;
        src_data1 = rst ? '0 : (wr_ok && dst_reg == src_reg1) ? dst_data : regs[src_reg1];
        src_data2 = rst ? '0 : (wr_ok && dst_reg == src_reg2) ? dst_data : regs[src_reg2];
        err_d     = rst ? 1'b0 : err_q | (write_reg && dst_reg == ZERO_REG);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
endmodule
